// File: rtl/key_conditioner_pkg.sv
// Shared widths and codes for the key conditioner and the play-mode block it feeds.
// The note priority helper lives here so both sides agree on the encoding.
package key_conditioner_pkg;

  localparam int CLOCK_BITS      = 32;
  localparam int NOTE_KEY_BITS   = 3;
  localparam int LENGTH_KEY_BITS = 4;
  localparam int NUM_NOTES       = 7;

  localparam logic [NOTE_KEY_BITS-1:0] NO_NOTE = 3'd7;

  // Lowest pressed index wins; NO_NOTE when nothing is held.
  function automatic logic [NOTE_KEY_BITS-1:0] lowest_note(input logic [NUM_NOTES-1:0] keys);
    lowest_note = NO_NOTE;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (keys[i]) lowest_note = NOTE_KEY_BITS'(i);
    end
  endfunction

endpackage

// File: rtl/key_conditioner_debounce_cell.sv
// One button input: two-flop synchroniser followed by a hold-time debouncer.
// The accepted level only moves after the new value has been seen for DEB_CYCLES cycles.
module key_conditioner_debounce_cell
  import key_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      // Any return to the accepted level restarts the hold window.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Button front end: debounces all raw inputs, encodes note/length/octave/hit for the
// play-mode block and runs the en-gated system_clock tick timestamp.
module key_conditioner #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEB_CYCLES  = CLK_HZ / 50,
  parameter int TICK_CYCLES = CLK_HZ / 1000,
  parameter int CLOCK_BITS  = key_conditioner_pkg::CLOCK_BITS,
  parameter int NUM_LEN     = key_conditioner_pkg::LENGTH_KEY_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [6:0]            note_btn,
  input  logic [NUM_LEN-1:0]    length_btn,
  input  logic                  oct_up_btn,
  input  logic                  oct_down_btn,
  input  logic                  hit_btn,
  output logic [2:0]            note_key,
  output logic [NUM_LEN-1:0]    length_key,
  output logic                  oct_up,
  output logic                  oct_down,
  output logic                  en_hit,
  output logic [CLOCK_BITS-1:0] system_clock
);
  import key_conditioner_pkg::*;

  localparam int NUM_RAW = NUM_NOTES + NUM_LEN + 3;
  localparam int UP_IDX  = NUM_NOTES + NUM_LEN;
  localparam int DN_IDX  = UP_IDX + 1;
  localparam int HIT_IDX = UP_IDX + 2;
  localparam int PRE_W   = $clog2(TICK_CYCLES);

  logic [NUM_RAW-1:0] raw_vec;
  logic [NUM_RAW-1:0] deb;
  logic               up_d;
  logic               down_d;
  logic               up_rise;
  logic               down_rise;
  logic [PRE_W-1:0]   prescaler;

  assign raw_vec = {hit_btn, oct_down_btn, oct_up_btn, length_btn, note_btn};

  for (genvar i = 0; i < NUM_RAW; i++) begin : g_deb
    key_conditioner_debounce_cell #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[i]),
      .level(deb[i])
    );
  end

  assign up_rise   = deb[UP_IDX] & ~up_d;
  assign down_rise = deb[DN_IDX] & ~down_d;

  // Edge history runs regardless of en, so an edge seen while disabled is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_key   <= NO_NOTE;
      length_key <= '0;
      en_hit     <= 1'b0;
      up_d       <= 1'b0;
      down_d     <= 1'b0;
      oct_up     <= 1'b0;
      oct_down   <= 1'b0;
    end else begin
      note_key   <= lowest_note(deb[NUM_NOTES-1:0]);
      length_key <= deb[NUM_NOTES +: NUM_LEN];
      en_hit     <= deb[HIT_IDX];
      up_d       <= deb[UP_IDX];
      down_d     <= deb[DN_IDX];
      oct_up     <= en & up_rise & ~down_rise;
      oct_down   <= en & down_rise & ~up_rise;
    end
  end

  // Timestamp saturates rather than wrapping so late hits never look early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= '0;
      system_clock <= '0;
    end else if (!en) begin
      prescaler    <= '0;
      system_clock <= '0;
    end else if (prescaler == PRE_W'(TICK_CYCLES - 1)) begin
      prescaler <= '0;
      if (system_clock != '1) system_clock <= system_clock + CLOCK_BITS'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: sample-history model checked every cycle plus directed
// literal expectations for latency, priority, glitch rejection, pulses and timestamp.
module tb_key_conditioner;

  localparam int DEB  = 4;
  localparam int TICK = 5;
  localparam int CB   = 4;
  localparam int NL   = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [6:0]    note_btn = '0;
  logic [NL-1:0] length_btn = '0;
  logic          oct_up_btn = 1'b0;
  logic          oct_down_btn = 1'b0;
  logic          hit_btn = 1'b0;
  logic [2:0]    note_key;
  logic [NL-1:0] length_key;
  logic          oct_up;
  logic          oct_down;
  logic          en_hit;
  logic [CB-1:0] system_clock;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEB_CYCLES (DEB),
    .TICK_CYCLES(TICK),
    .CLOCK_BITS (CB),
    .NUM_LEN    (NL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .note_btn    (note_btn),
    .length_btn  (length_btn),
    .oct_up_btn  (oct_up_btn),
    .oct_down_btn(oct_down_btn),
    .hit_btn     (hit_btn),
    .note_key    (note_key),
    .length_key  (length_key),
    .oct_up      (oct_up),
    .oct_down    (oct_down),
    .en_hit      (en_hit),
    .system_clock(system_clock)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: a level is accepted once raw has held a new value for DEB samples;
  // the output reflects that acceptance three edges later.
  logic [13:0] raw_s;
  logic [13:0] last_s;
  logic [13:0] lvl;
  logic [13:0] hist [5];
  int          run [14];
  bit          have_last;
  int          en_run;
  logic        en_k;

  assign raw_s = {hit_btn, oct_down_btn, oct_up_btn, length_btn, note_btn};

  always @(posedge clk) begin
    if (!rst_n) begin
      lvl = '0;
      last_s = '0;
      have_last = 1'b0;
      en_run = 0;
      en_k = 1'b0;
      for (int i = 0; i < 5; i++) hist[i] = '0;
      for (int i = 0; i < 14; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (have_last && raw_s[i] == last_s[i]) run[i] = (run[i] < DEB) ? run[i] + 1 : DEB;
        else run[i] = 1;
        if (run[i] >= DEB && raw_s[i] != lvl[i]) lvl[i] = raw_s[i];
      end
      have_last = 1'b1;
      last_s = raw_s;
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = lvl;
      en_k = en;
      en_run = en ? en_run + 1 : 0;
    end
  end

  logic [13:0] cur_v;
  logic [13:0] prv_v;
  int          e_note;
  int          e_clk;
  logic        e_up;
  logic        e_dn;

  always @(negedge clk) begin
    if (cmp_on) begin
      if (!rst_n) begin
        check("cyc_rst_note", note_key, 7);
        check("cyc_rst_len", length_key, 0);
        check("cyc_rst_up", oct_up, 0);
        check("cyc_rst_dn", oct_down, 0);
        check("cyc_rst_hit", en_hit, 0);
        check("cyc_rst_clock", system_clock, 0);
      end else begin
        cur_v = hist[3];
        prv_v = hist[4];
        e_note = 7;
        for (int i = 6; i >= 0; i--) if (cur_v[i]) e_note = i;
        e_up = en_k & cur_v[11] & ~prv_v[11] & ~(cur_v[12] & ~prv_v[12]);
        e_dn = en_k & cur_v[12] & ~prv_v[12] & ~(cur_v[11] & ~prv_v[11]);
        e_clk = (en_run / TICK > CMAX) ? CMAX : en_run / TICK;
        check("cyc_note", note_key, e_note);
        check("cyc_len", length_key, int'(cur_v[10:7]));
        check("cyc_hit", en_hit, cur_v[13]);
        check("cyc_up", oct_up, e_up);
        check("cyc_dn", oct_down, e_dn);
        check("cyc_clock", system_clock, e_clk);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_pulses(input int n, output int ups, output int dns);
    ups = 0;
    dns = 0;
    repeat (n) begin
      step(1);
      ups += int'(oct_up);
      dns += int'(oct_down);
    end
  endtask

  int ups;
  int dns;

  initial begin
    #3 rst_n = 1'b0;
    cmp_on = 1'b1;
    step(3);
    check("rst_note", note_key, 7);
    check("rst_clock", system_clock, 0);
    rst_n = 1'b1;
    step(50);
    check("idle_note", note_key, 7);
    check("idle_len", length_key, 0);
    check("idle_clock", system_clock, 0);

    note_btn = 7'b0000100;
    step(6);
    check("note_t6", note_key, 7);
    step(1);
    check("note_t7", note_key, 2);
    note_btn = 7'b0100100;
    step(10);
    check("note_multi", note_key, 2);
    note_btn = 7'b0100000;
    step(6);
    check("note_rel_t6", note_key, 2);
    step(1);
    check("note_rel_t7", note_key, 5);
    note_btn = '0;
    step(10);
    check("note_none", note_key, 7);

    note_btn = 7'b0000001;
    step(3);
    note_btn = '0;
    step(10);
    check("glitch3", note_key, 7);
    note_btn = 7'b0000001;
    step(4);
    note_btn = '0;
    step(3);
    check("hold4", note_key, 0);
    step(10);

    length_btn = 4'b1010;
    hit_btn = 1'b1;
    step(7);
    check("len_lvl", length_key, 10);
    check("hit_lvl", en_hit, 1);
    length_btn = '0;
    hit_btn = 1'b0;
    step(10);

    en = 1'b1;
    step(23);
    check("clock_23", system_clock, 4);
    en = 1'b0;
    step(1);
    check("clock_drop", system_clock, 0);
    en = 1'b1;
    step(80);
    check("clock_sat", system_clock, CMAX);
    step(7);
    check("clock_sat_hold", system_clock, CMAX);

    oct_up_btn = 1'b1;
    count_pulses(30, ups, dns);
    check("up_hold_pulses", ups, 1);
    check("up_hold_dn", dns, 0);
    oct_up_btn = 1'b0;
    count_pulses(10, ups, dns);
    check("up_release", ups, 0);

    oct_up_btn = 1'b1;
    oct_down_btn = 1'b1;
    count_pulses(15, ups, dns);
    check("both_up", ups, 0);
    check("both_dn", dns, 0);
    oct_up_btn = 1'b0;
    oct_down_btn = 1'b0;
    step(10);

    oct_down_btn = 1'b1;
    count_pulses(12, ups, dns);
    check("dn_alone", dns, 1);
    oct_down_btn = 1'b0;
    step(10);

    en = 1'b0;
    oct_up_btn = 1'b1;
    count_pulses(12, ups, dns);
    check("up_en_off", ups, 0);
    en = 1'b1;
    count_pulses(12, ups, dns);
    check("up_not_deferred", ups, 0);
    oct_up_btn = 1'b0;
    en = 1'b0;
    step(10);

    note_btn = 7'b0001000;
    step(10);
    check("pre_rst_note", note_key, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_note", note_key, 7);
    step(2);
    rst_n = 1'b1;
    step(6);
    check("requal_t6", note_key, 7);
    step(1);
    check("requal_t7", note_key, 3);
    note_btn = '0;
    step(10);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
